// File: rtl/sub8_serial.sv
// Bit-serial W-bit subtractor: O = {borrow, A - B}, computed as A + ~B + 1, UNROLL bits per cycle, LSB first.
// Optional zero flag on the difference is enabled by defining SUB8_SERIAL_ZFLAG_EN.
module sub8_serial #(
  parameter int W      = 8,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   O
`ifdef SUB8_SERIAL_ZFLAG_EN
  ,
  output logic         zero
`endif
);

  localparam int NSL = W / UNROLL;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_sh, b_sh, diff_sh, diff_nx;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [UNROLL:0] slice;
  logic            last;

  assign slice = {1'b0, a_sh[UNROLL-1:0]} + {1'b0, b_sh[UNROLL-1:0]} + {{UNROLL{1'b0}}, carry};
  assign last  = (cnt == CW'(NSL - 1));
  // New slice enters at the top; the shift also covers UNROLL == W without a zero-width slice.
  assign diff_nx = W'({slice[UNROLL-1:0], diff_sh} >> UNROLL);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      O       <= '0;
`ifdef SUB8_SERIAL_ZFLAG_EN
      zero    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= A;
            b_sh  <= ~B;
            carry <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> UNROLL;
          b_sh    <= b_sh >> UNROLL;
          carry   <= slice[UNROLL];
          diff_sh <= diff_nx;
          cnt     <= cnt + CW'(1);
          if (last) begin
            O <= {~slice[UNROLL], diff_nx};
`ifdef SUB8_SERIAL_ZFLAG_EN
            zero <= (diff_nx == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub8_serial.sv
// Directed and random checks of sub8_serial at UNROLL=1 (main), 4 and 8.
module tb_sub8_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a, b;
  logic       iv0, ir0, ov0, ordy0;
  logic       iv4, ir4, ov4, ordy4;
  logic       iv8, ir8, ov8, ordy8;
  logic [8:0] o0, o4, o8;
`ifdef SUB8_SERIAL_ZFLAG_EN
  logic       z0, z4, z8;
`endif

  int checks = 0;
  int errors = 0;

  sub8_serial #(.W(8), .UNROLL(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a), .B(b),
    .out_valid(ov0), .out_ready(ordy0), .O(o0)
`ifdef SUB8_SERIAL_ZFLAG_EN
    , .zero(z0)
`endif
  );

  sub8_serial #(.W(8), .UNROLL(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a), .B(b),
    .out_valid(ov4), .out_ready(ordy4), .O(o4)
`ifdef SUB8_SERIAL_ZFLAG_EN
    , .zero(z4)
`endif
  );

  sub8_serial #(.W(8), .UNROLL(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a), .B(b),
    .out_valid(ov8), .out_ready(ordy8), .O(o8)
`ifdef SUB8_SERIAL_ZFLAG_EN
    , .zero(z8)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full transaction on u0 with out_ready=1; operands are scrambled right after accept.
  task automatic do_op0(input logic [7:0] x, input logic [7:0] y,
                        output logic [8:0] res, output int lat, output logic z);
    a = x; b = y; iv0 = 1'b1; ordy0 = 1'b1;
    step;
    iv0 = 1'b0; a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    while (!ov0 && lat < 40) begin
      step;
      lat++;
    end
    res = o0;
`ifdef SUB8_SERIAL_ZFLAG_EN
    z = z0;
`else
    z = 1'b0;
`endif
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1; iv0 = 0; iv4 = 0; iv8 = 0; ordy0 = 1; ordy4 = 1; ordy8 = 1; a = 0; b = 0;
    step; step;
    rst = 1'b0;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready0: got %b want 1", ir0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid0: got %b want 0", ov0); end
    checks++; if (o0 !== 9'h000) begin errors++; $display("FAIL reset_O0: got %h want 000", o0); end
    checks++; if ({ir4, ov4, o4} !== {1'b1, 1'b0, 9'h000}) begin errors++; $display("FAIL reset_u4: got ir=%b ov=%b O=%h want 1 0 000", ir4, ov4, o4); end
    checks++; if ({ir8, ov8, o8} !== {1'b1, 1'b0, 9'h000}) begin errors++; $display("FAIL reset_u8: got ir=%b ov=%b O=%h want 1 0 000", ir8, ov8, o8); end
`ifdef SUB8_SERIAL_ZFLAG_EN
    checks++; if (z0 !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", z0); end
`endif
  endtask

  task automatic test_subtract;
    logic [7:0] va [6] = '{8'd200, 8'd55,  8'd0, 8'd0,   8'hAA, 8'd10};
    logic [7:0] vb [6] = '{8'd55,  8'd200, 8'd1, 8'd255, 8'hAA, 8'd3};
    logic [8:0] ve [6] = '{9'h091, 9'h16F, 9'h1FF, 9'h101, 9'h000, 9'h007};
    logic [8:0] res;
    int lat;
    logic z;
    for (int i = 0; i < 6; i++) begin
      do_op0(va[i], vb[i], res, lat, z);
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL sub_O[%0d]: got %h want %h", i, res, ve[i]); end
      checks++; if (lat !== 8) begin errors++; $display("FAIL sub_latency[%0d]: got %0d want 8", i, lat); end
    end
  endtask

  task automatic test_zero;
    logic [8:0] res;
    int lat;
    logic z;
    do_op0(8'hAA, 8'hAA, res, lat, z);
    checks++; if (res !== 9'h000) begin errors++; $display("FAIL zero_eq_O: got %h want 000", res); end
`ifdef SUB8_SERIAL_ZFLAG_EN
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL zero_eq_flag: got %b want 1", z); end
`endif
    do_op0(8'h01, 8'h00, res, lat, z);
    checks++; if (res !== 9'h001) begin errors++; $display("FAIL zero_ne_O: got %h want 001", res); end
`ifdef SUB8_SERIAL_ZFLAG_EN
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL zero_ne_flag: got %b want 0", z); end
`endif
  endtask

  task automatic test_hold;
    logic [8:0] res;
    int lat;
    logic z;
    a = 8'h3C; b = 8'h0F; iv0 = 1'b1; ordy0 = 1'b0;
    step;
    iv0 = 1'b0;
    lat = 0;
    while (!ov0 && lat < 40) begin step; lat++; end
    checks++; if (lat !== 8) begin errors++; $display("FAIL hold_latency: got %0d want 8", lat); end
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); iv0 = (i % 2 == 0);
      step;
      checks++; if ({ov0, ir0, o0} !== {1'b1, 1'b0, 9'h02D}) begin
        errors++; $display("FAIL hold_stable[%0d]: got ov=%b ir=%b O=%h want 1 0 02D", i, ov0, ir0, o0);
      end
    end
    // in_valid high on the hand-off edge must not be taken.
    iv0 = 1'b1; a = 8'h77; b = 8'h11; ordy0 = 1'b1;
    step;
    iv0 = 1'b0;
    checks++; if ({ov0, ir0} !== 2'b01) begin errors++; $display("FAIL hold_handoff: got ov=%b ir=%b want 0 1", ov0, ir0); end
    do_op0(8'h05, 8'h09, res, lat, z);
    checks++; if (res !== 9'h1FC) begin errors++; $display("FAIL hold_next_O: got %h want 1FC", res); end
  endtask

  task automatic test_reset_mid_run;
    logic [8:0] res;
    int lat, nv;
    logic z;
    a = 8'h77; b = 8'h11; iv0 = 1'b1; ordy0 = 1'b1;
    step;
    iv0 = 1'b0;
    step; step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++; if ({ov0, ir0, o0} !== {1'b0, 1'b1, 9'h000}) begin
      errors++; $display("FAIL midrst_state: got ov=%b ir=%b O=%h want 0 1 000", ov0, ir0, o0);
    end
    nv = 0;
    for (int i = 0; i < 12; i++) begin step; if (ov0) nv++; end
    checks++; if (nv !== 0) begin errors++; $display("FAIL midrst_no_output: got %0d valid cycles want 0", nv); end
    do_op0(8'd10, 8'd3, res, lat, z);
    checks++; if (res !== 9'h007) begin errors++; $display("FAIL midrst_next_O: got %h want 007", res); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_next_latency: got %0d want 8", lat); end
  endtask

  task automatic test_unroll_random;
    logic [7:0] x, y;
    logic [8:0] expv, r4, r8;
    int l4, l8;
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom); y = 8'($urandom);
      expv = {1'b0, x} - {1'b0, y};
      a = x; b = y; iv4 = 1'b1; iv8 = 1'b1; ordy4 = 1'b1; ordy8 = 1'b1;
      step;
      iv4 = 1'b0; iv8 = 1'b0;
      l4 = -1; l8 = -1; r4 = '0; r8 = '0;
      for (int k = 1; k <= 5; k++) begin
        if (k == 1) begin a = 8'($urandom); b = 8'($urandom); end
        step;
        if (ov4 && l4 < 0) begin l4 = k; r4 = o4; end
        if (ov8 && l8 < 0) begin l8 = k; r8 = o8; end
      end
      checks++; if (r4 !== expv) begin errors++; $display("FAIL u4_O: A=%h B=%h got %h want %h", x, y, r4, expv); end
      checks++; if (l4 !== 2) begin errors++; $display("FAIL u4_latency: got %0d want 2", l4); end
      checks++; if (r8 !== expv) begin errors++; $display("FAIL u8_O: A=%h B=%h got %h want %h", x, y, r8, expv); end
      checks++; if (l8 !== 1) begin errors++; $display("FAIL u8_latency: got %0d want 1", l8); end
    end
  endtask

  task automatic test_back_to_back;
    int n0, n4, n8;
    n0 = 0; n4 = 0; n8 = 0;
    a = 8'd20; b = 8'd7;
    iv0 = 1'b1; iv4 = 1'b1; iv8 = 1'b1; ordy0 = 1'b1; ordy4 = 1'b1; ordy8 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step;
      if (ov0) n0++;
      if (ov4) n4++;
      if (ov8) n8++;
    end
    iv0 = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
    checks++; if (n0 !== 4)  begin errors++; $display("FAIL b2b_u0_count: got %0d want 4", n0); end
    checks++; if (n4 !== 10) begin errors++; $display("FAIL b2b_u4_count: got %0d want 10", n4); end
    checks++; if (n8 !== 13) begin errors++; $display("FAIL b2b_u8_count: got %0d want 13", n8); end
    checks++; if ({o0, o4, o8} !== {9'h00D, 9'h00D, 9'h00D}) begin
      errors++; $display("FAIL b2b_O: got %h %h %h want 00D 00D 00D", o0, o4, o8);
    end
    for (int i = 0; i < 12; i++) step;
  endtask

  initial begin
    test_reset;
    test_subtract;
    test_zero;
    test_hold;
    test_reset_mid_run;
    test_unroll_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
